// File: rtl/ped_signal_ctrl_if.sv
// Pedestrian controller bundle: upstream vehicle lamps and button in, pedestrian lamps and status out.
// master drives the stimulus side; slave is the controller.
interface ped_signal_ctrl_if;
    logic power_red;
    logic power_yellow;
    logic power_green;
    logic ped_button;
    logic walk;
    logic dont_walk;
    logic req_pending;
    logic abort;
    logic fault;

    modport master (
        output power_red, power_yellow, power_green, ped_button,
        input  walk, dont_walk, req_pending, abort, fault
    );

    modport slave (
        input  power_red, power_yellow, power_green, ped_button,
        output walk, dont_walk, req_pending, abort, fault
    );
endinterface

// File: rtl/ped_signal_ctrl.sv
// Grants WALK at the next vehicle red rise after a request, then flashes a clearance; latches lamp conflicts.
// One-cycle registered latency on every output; no backpressure, inputs are consumed every cycle.
module ped_signal_ctrl #(
    parameter int WALK_LENGTH  = 8,
    parameter int FLASH_LENGTH = 6,
    parameter int FLASH_PERIOD = 2
) (
    input  logic            clk,
    input  logic            reset,
    ped_signal_ctrl_if.slave bus
);
    localparam int MAX_LEN = (WALK_LENGTH > FLASH_LENGTH) ? WALK_LENGTH : FLASH_LENGTH;
    localparam int CW      = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {IDLE, WALK, CLEAR, FAULT} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            prev_red, prev_btn;
    logic            walk_q, dont_walk_q, req_q, abort_q, fault_q;
    logic            walk_n, dont_walk_n, req_n, abort_n, fault_n;
    logic            red_rise, btn_rise, conflict;
    logic [31:0]     flash_phase;

    assign red_rise = bus.power_red & ~prev_red;
    assign btn_rise = bus.ped_button & ~prev_btn;
    assign conflict = (bus.power_red & bus.power_yellow) |
                      (bus.power_red & bus.power_green)  |
                      (bus.power_yellow & bus.power_green);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        req_n       = req_q;
        abort_n     = 1'b0;
        walk_n      = 1'b0;
        dont_walk_n = 1'b1;
        fault_n     = 1'b0;
        flash_phase = 32'd0;

        if (state == FAULT) begin
            req_n = 1'b0;
        end else if (conflict) begin
            state_n = FAULT;
            cnt_n   = '0;
            req_n   = 1'b0;
        end else begin
            if (btn_rise) req_n = 1'b1;
            case (state)
                IDLE: begin
                    // Grants only on the rising edge of red, never partway through a red phase.
                    if (red_rise && (req_q || btn_rise)) begin
                        state_n = WALK;
                        cnt_n   = '0;
                        req_n   = 1'b0;
                    end
                end
                WALK: begin
                    if (!bus.power_red) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        abort_n = 1'b1;
                    end else if (cnt == CW'(WALK_LENGTH - 1)) begin
                        state_n = CLEAR;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                CLEAR: begin
                    if (!bus.power_red) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        abort_n = 1'b1;
                    end else if (cnt == CW'(FLASH_LENGTH - 1)) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n = FAULT;
                end
            endcase
        end

        // Lamp outputs are decoded from the next state so they register alongside it.
        case (state_n)
            WALK: begin
                walk_n      = 1'b1;
                dont_walk_n = 1'b0;
            end
            CLEAR: begin
                flash_phase = 32'(cnt_n) / FLASH_PERIOD;
                dont_walk_n = ~flash_phase[0];
            end
            FAULT: begin
                fault_n = 1'b1;
            end
            default: begin
                dont_walk_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            prev_red    <= 1'b0;
            prev_btn    <= 1'b0;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            req_q       <= 1'b0;
            abort_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            prev_red    <= bus.power_red;
            prev_btn    <= bus.ped_button;
            walk_q      <= walk_n;
            dont_walk_q <= dont_walk_n;
            req_q       <= req_n;
            abort_q     <= abort_n;
            fault_q     <= fault_n;
        end
    end

    assign bus.walk        = walk_q;
    assign bus.dont_walk   = dont_walk_q;
    assign bus.req_pending = req_q;
    assign bus.abort       = abort_q;
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Directed bench for ped_signal_ctrl with default parameters (walk 8, flash 6, flash half-period 2).
module tb_ped_signal_ctrl;
    logic clk;
    logic reset;
    int   vectors;
    int   errors;

    ped_signal_ctrl_if pif();

    ped_signal_ctrl #(
        .WALK_LENGTH (8),
        .FLASH_LENGTH(6),
        .FLASH_PERIOD(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic w, input logic dw,
                           input logic rq, input logic ab, input logic f);
        chk({tag, ".walk"},        pif.walk,        w);
        chk({tag, ".dont_walk"},   pif.dont_walk,   dw);
        chk({tag, ".req_pending"}, pif.req_pending, rq);
        chk({tag, ".abort"},       pif.abort,       ab);
        chk({tag, ".fault"},       pif.fault,       f);
    endtask

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lamps(input logic r, input logic y, input logic g);
        pif.power_red    = r;
        pif.power_yellow = y;
        pif.power_green  = g;
    endtask

    initial begin
        logic [5:0] flash_exp;
        vectors   = 0;
        errors    = 0;
        flash_exp = 6'b110011;
        reset     = 1'b1;
        lamps(1'b0, 1'b0, 1'b0);
        pif.ped_button = 1'b0;
        tick();
        tick();
        chk_all("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Normal grant
        lamps(1'b0, 1'b0, 1'b1);
        tick();
        tick();
        pif.ped_button = 1'b1;
        tick();
        chk("grant.req_set", pif.req_pending, 1'b1);
        pif.ped_button = 1'b0;
        tick();
        chk("grant.req_hold", pif.req_pending, 1'b1);
        chk("grant.no_walk_green", pif.walk, 1'b0);
        lamps(1'b1, 1'b0, 1'b0);
        tick();
        chk_all("grant.walk1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk($sformatf("grant.walk%0d", i), pif.walk, 1'b1);
            chk($sformatf("grant.dw_walk%0d", i), pif.dont_walk, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("grant.clear%0d_walk", i), pif.walk, 1'b0);
            chk($sformatf("grant.clear%0d_dw", i), pif.dont_walk, flash_exp[5-i]);
        end
        tick();
        chk_all("grant.idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Late request: press 3 cycles after red rise
        lamps(1'b0, 1'b1, 1'b0);
        tick();
        lamps(1'b0, 1'b0, 1'b1);
        tick();
        lamps(1'b1, 1'b0, 1'b0);
        tick();
        chk("late.no_walk_rise", pif.walk, 1'b0);
        tick();
        tick();
        pif.ped_button = 1'b1;
        tick();
        chk("late.req_set", pif.req_pending, 1'b1);
        pif.ped_button = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("late.no_walk%0d", i), pif.walk, 1'b0);
        end
        chk("late.req_hold", pif.req_pending, 1'b1);
        lamps(1'b0, 1'b0, 1'b1);
        tick();
        tick();
        lamps(1'b1, 1'b0, 1'b0);
        tick();
        chk_all("late.walk_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort: red drops during walk cycle 4
        tick();
        tick();
        tick();
        chk("abort.walk4", pif.walk, 1'b1);
        lamps(1'b0, 1'b0, 1'b1);
        tick();
        chk_all("abort.pulse", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("abort.after", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Coincident press with red rise
        lamps(1'b1, 1'b0, 1'b0);
        pif.ped_button = 1'b1;
        tick();
        chk_all("coinc.walk", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pif.ped_button = 1'b0;
        tick();
        chk("coinc.req_low", pif.req_pending, 1'b0);

        // Conflict mid-walk, then sticky until reset
        lamps(1'b1, 1'b0, 1'b1);
        tick();
        chk_all("conflict.enter", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        lamps(1'b1, 1'b0, 1'b0);
        tick();
        chk("conflict.sticky", pif.fault, 1'b1);
        pif.ped_button = 1'b1;
        tick();
        chk("conflict.btn_ignored", pif.req_pending, 1'b0);
        pif.ped_button = 1'b0;
        lamps(1'b0, 1'b0, 1'b1);
        tick();
        lamps(1'b1, 1'b0, 1'b0);
        tick();
        chk_all("conflict.red_rise", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        chk_all("conflict.reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Reset mid-clear with a pending request
        lamps(1'b0, 1'b0, 1'b1);
        tick();
        lamps(1'b1, 1'b0, 1'b0);
        pif.ped_button = 1'b1;
        tick();
        chk("rstclr.walk", pif.walk, 1'b1);
        pif.ped_button = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("rstclr.in_clear_walk", pif.walk, 1'b0);
        chk("rstclr.in_clear_dw", pif.dont_walk, 1'b1);
        pif.ped_button = 1'b1;
        tick();
        chk("rstclr.req_set", pif.req_pending, 1'b1);
        pif.ped_button = 1'b0;
        reset = 1'b1;
        tick();
        chk_all("rstclr.reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        lamps(1'b0, 1'b0, 1'b1);
        tick();
        lamps(1'b1, 1'b0, 1'b0);
        tick();
        chk_all("rstclr.no_walk", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rstclr.still_no_walk", pif.walk, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
